// File: rtl/cpu_line_responder_pkg.sv
// Shared types and helpers for the CPU line responder: FSM states, line geometry
// and the byte-lane merge used when a CPU write lands in the line buffer.
package cpu_line_responder_pkg;

    localparam int S_OFFSET = 5;
    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 8 << S_OFFSET;
    localparam int WORDS    = LINE_W / 32;
    localparam int IDX_W    = S_OFFSET - 2;
    localparam int TAG_W    = ADDR_W - S_OFFSET;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MERGE,
        WB,
        RESP
    } state_t;

    // Replace the enabled byte lanes of word idx with wdata; everything else is kept.
    function automatic logic [LINE_W-1:0] merge_word(
        input logic [LINE_W-1:0] line,
        input logic [IDX_W-1:0]  idx,
        input logic [31:0]       wdata,
        input logic [3:0]        be
    );
        logic [LINE_W-1:0] result;
        result = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                result[int'(idx) * 32 + b * 8 +: 8] = wdata[b * 8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cpu_line_responder_line_buffer.sv
// Single-entry line buffer: valid/tag/data registers with a whole-line load port,
// a byte-lane merge port and a word-select read port.
module line_buffer
    import cpu_line_responder_pkg::*;
#(
    parameter int s_offset   = S_OFFSET,
    parameter int addr_width = ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_en,
    input  logic [addr_width-s_offset-1:0] load_tag,
    input  logic [(8<<s_offset)-1:0]     load_data,
    input  logic                         merge_en,
    input  logic [s_offset-3:0]          merge_idx,
    input  logic [31:0]                  merge_wdata,
    input  logic [3:0]                   merge_be,
    input  logic [s_offset-3:0]          rd_idx,
    output logic                         buf_valid,
    output logic [addr_width-s_offset-1:0] buf_tag,
    output logic [(8<<s_offset)-1:0]     buf_data,
    output logic [31:0]                  rd_word
);

    localparam int line_words = (8 << s_offset) / 32;

    logic [31:0] word_arr [line_words];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (load_en) begin
            buf_valid <= 1'b1;
            buf_tag   <= load_tag;
            buf_data  <= load_data;
        end else if (merge_en) begin
            buf_data  <= merge_word(buf_data, merge_idx, merge_wdata, merge_be);
        end
    end

    generate
        for (genvar gi = 0; gi < line_words; gi++) begin : g_word
            assign word_arr[gi] = buf_data[gi * 32 +: 32];
        end
    endgenerate

    assign rd_word = word_arr[rd_idx];

endmodule

// File: rtl/cpu_line_responder.sv
// Word-to-line memory responder: serves 32-bit CPU accesses from a one-line buffer,
// fetching lines on a miss and writing every store through to physical memory.
module cpu_line_responder
    import cpu_line_responder_pkg::*;
#(
    parameter int s_offset   = S_OFFSET,
    parameter int addr_width = ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [3:0]              mem_byte_enable,
    input  logic [addr_width-1:0]   mem_address,
    input  logic [31:0]             mem_wdata,
    output logic                    mem_resp,
    output logic [31:0]             mem_rdata,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [addr_width-1:0]   pmem_address,
    output logic [(8<<s_offset)-1:0] pmem_wdata,
    input  logic [(8<<s_offset)-1:0] pmem_rdata,
    input  logic                    pmem_resp
);

    localparam int line_w = 8 << s_offset;
    localparam int tag_w  = addr_width - s_offset;
    localparam int idx_w  = s_offset - 2;

    state_t                    state_reg, state_next;
    logic [addr_width-1:2]     word_addr_reg;
    logic [31:0]               wdata_reg;
    logic [3:0]                be_reg;
    logic                      write_reg;

    logic                      buf_valid;
    logic [tag_w-1:0]          buf_tag;
    logic [line_w-1:0]         buf_data;
    logic [31:0]               rd_word;
    logic                      load_en;
    logic                      merge_en;
    logic                      accept;

    logic [tag_w-1:0]          req_tag;
    logic [tag_w-1:0]          lat_tag;
    logic [idx_w-1:0]          lat_idx;
    logic                      req_hit;
    logic [addr_width-1:0]     line_addr;
    logic                      unused_byte_offset;

    assign req_tag            = mem_address[addr_width-1:s_offset];
    assign lat_tag            = word_addr_reg[addr_width-1:s_offset];
    assign lat_idx            = word_addr_reg[s_offset-1:2];
    assign req_hit            = buf_valid && (buf_tag == req_tag);
    assign line_addr          = {lat_tag, {s_offset{1'b0}}};
    assign accept             = (state_reg == IDLE) && (mem_read || mem_write);
    assign unused_byte_offset = ^mem_address[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            word_addr_reg <= '0;
            wdata_reg     <= '0;
            be_reg        <= '0;
            write_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                word_addr_reg <= mem_address[addr_width-1:2];
                wdata_reg     <= mem_wdata;
                be_reg        <= mem_byte_enable;
                write_reg     <= mem_write;
            end
        end
    end

    // Hit/miss is decided on the incoming address, which is the value being latched.
    always_comb begin
        state_next = state_reg;
        load_en    = 1'b0;
        merge_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_write) begin
                    state_next = req_hit ? MERGE : FETCH;
                end else if (mem_read) begin
                    state_next = req_hit ? RESP : FETCH;
                end
            end
            FETCH: begin
                if (pmem_resp) begin
                    load_en    = 1'b1;
                    state_next = write_reg ? MERGE : RESP;
                end
            end
            MERGE: begin
                merge_en   = 1'b1;
                state_next = WB;
            end
            WB: begin
                if (pmem_resp) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mem_resp     = (state_reg == RESP);
    assign mem_rdata    = mem_resp ? rd_word : '0;
    assign pmem_read    = (state_reg == FETCH);
    assign pmem_write   = (state_reg == WB);
    assign pmem_address = (pmem_read || pmem_write) ? line_addr : '0;
    assign pmem_wdata   = pmem_write ? buf_data : '0;

    line_buffer #(
        .s_offset   (s_offset),
        .addr_width (addr_width)
    ) u_line_buffer (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_tag    (lat_tag),
        .load_data   (pmem_rdata),
        .merge_en    (merge_en),
        .merge_idx   (lat_idx),
        .merge_wdata (wdata_reg),
        .merge_be    (be_reg),
        .rd_idx      (lat_idx),
        .buf_valid   (buf_valid),
        .buf_tag     (buf_tag),
        .buf_data    (buf_data),
        .rd_word     (rd_word)
    );

endmodule

// File: tb/tb_cpu_line_responder.sv
// Self-checking bench for cpu_line_responder: directed scenarios plus random traffic
// compared against a line-level memory/buffer model with a variable-latency responder.
module tb_cpu_line_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address, mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    cpu_line_responder dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    typedef struct {
        bit           is_write;
        logic [31:0]  addr;
        logic [255:0] data;
    } ptx_t;

    int           n_vec = 0;
    int           n_miss = 0;
    int           n_req = 0;
    int           resp_total = 0;
    int           stab_err = 0;
    int           both_err = 0;
    int           lat_fixed = 0;
    ptx_t         plog [$];
    logic [255:0] phys_mem [32];
    logic [255:0] ref_mem [32];
    bit           ref_valid = 1'b0;
    logic [31:0]  ref_line = '0;

    function automatic logic [255:0] init_line(input int l);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k * 32 +: 32] = 32'h1111_0000 + 32'((l ^ 8) << 8) + 32'(k);
        end
        return r;
    endfunction

    // Physical memory: holds each request for lat cycles, then pulses pmem_resp once.
    initial begin
        bit   busy;
        int   cnt;
        int   lat;
        ptx_t cur;
        busy = 1'b0; cnt = 0; lat = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_read && pmem_write) both_err++;
            if (!rst) begin
                busy = 1'b0;
                pmem_resp = 1'b0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    cur.is_write = pmem_write;
                    cur.addr = pmem_address;
                    cur.data = pmem_wdata;
                    lat = (lat_fixed < 0) ? int'($urandom_range(7, 0)) : lat_fixed;
                end else begin
                    cnt++;
                    if (pmem_address !== cur.addr || pmem_wdata !== cur.data || pmem_write !== cur.is_write)
                        stab_err++;
                end
                if (cnt == lat) begin
                    if (cur.is_write) begin
                        phys_mem[cur.addr[9:5]] = cur.data;
                    end else begin
                        pmem_rdata = phys_mem[cur.addr[9:5]];
                        cur.data = pmem_rdata;
                    end
                    plog.push_back(cur);
                    pmem_resp = 1'b1;
                    busy = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_resp === 1'b1) resp_total++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One CPU access, presented the cycle after the previous response.
    task automatic cpu_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, output logic [31:0] rd, output int cyc,
                              output int log_at_resp, output bit timeout);
        @(negedge clk);
        mem_read = !wr; mem_write = wr;
        mem_address = a; mem_wdata = d; mem_byte_enable = b;
        cyc = 0; timeout = 1'b1; rd = 'x; log_at_resp = plog.size();
        n_req++;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (mem_resp === 1'b1) begin
                rd = mem_rdata;
                log_at_resp = plog.size();
                timeout = 1'b0;
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        $display("txn %s addr=%h wdata=%h be=%b rdata=%h cycles=%0d", wr ? "WR" : "RD", a, d, b, rd, cyc);
    endtask

    // Line-level model: one buffered line, write-through memory.
    task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] b, output int exp_rd, output int exp_wr,
                                output logic [255:0] exp_line, output logic [31:0] exp_word);
        logic [31:0] line;
        int          w;
        int          li;
        line = {a[31:5], 5'b0};
        w = int'(a[4:2]);
        li = int'(a[9:5]);
        exp_rd = (ref_valid && ref_line == line) ? 0 : 1;
        ref_valid = 1'b1;
        ref_line = line;
        exp_line = ref_mem[li];
        exp_wr = 0;
        if (wr) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) exp_line[w * 32 + k * 8 +: 8] = d[k * 8 +: 8];
            ref_mem[li] = exp_line;
            exp_wr = 1;
        end
        exp_word = exp_line[w * 32 +: 32];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
        mem_address = '0; mem_wdata = '0;
        for (int l = 0; l < 32; l++) begin
            phys_mem[l] = init_line(l);
            ref_mem[l] = init_line(l);
        end
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata} !== '0) begin
            n_miss++;
            $display("FAIL reset_outputs: got resp=%b rdata=%h pr=%b pw=%b pa=%h, want all zero",
                     mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_read_miss_hit();
        logic [31:0] rd, ew; logic [255:0] el; int cyc, at, er, ewr, s; bit to;
        lat_fixed = 2;
        s = plog.size();
        model_access(1'b0, 32'h108, '0, '0, er, ewr, el, ew);
        cpu_access(1'b0, 32'h108, '0, '0, rd, cyc, at, to);
        n_vec++;
        if (to || rd !== 32'h1111_0002 || rd !== ew) begin
            n_miss++; $display("FAIL read_miss_data: got %h timeout=%0d, want 11110002", rd, to);
        end
        n_vec++;
        if (at - s != 1 || plog[s].is_write || plog[s].addr !== 32'h100) begin
            n_miss++; $display("FAIL read_miss_pmem: got %0d txns, want 1 read at 00000100", at - s);
        end
        s = plog.size();
        model_access(1'b0, 32'h10C, '0, '0, er, ewr, el, ew);
        cpu_access(1'b0, 32'h10C, '0, '0, rd, cyc, at, to);
        n_vec++;
        if (to || rd !== 32'h1111_0003 || cyc != 1 || plog.size() != s) begin
            n_miss++; $display("FAIL read_hit: got rdata=%h cycles=%0d txns=%0d, want 11110003 1 0", rd, cyc, plog.size() - s);
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd, ew; logic [255:0] el; int cyc, at, er, ewr, s, r0; bit to;
        s = plog.size();
        r0 = resp_total;
        model_access(1'b1, 32'h108, 32'hAABB_CCDD, 4'b0101, er, ewr, el, ew);
        cpu_access(1'b1, 32'h108, 32'hAABB_CCDD, 4'b0101, rd, cyc, at, to);
        @(negedge clk);
        n_vec++;
        if (to || at - s != 1 || !plog[s].is_write || plog[s].addr !== 32'h100) begin
            n_miss++; $display("FAIL write_hit_pmem: got %0d txns timeout=%0d, want 1 write at 00000100", at - s, to);
        end
        n_vec++;
        if (plog[s].data[95:64] !== 32'h11BB_00DD || plog[s].data !== el) begin
            n_miss++; $display("FAIL write_hit_line: got word2=%h, want 11bb00dd with other words unchanged", plog[s].data[95:64]);
        end
        n_vec++;
        if (rd !== 32'h11BB_00DD || resp_total - r0 != 1) begin
            n_miss++; $display("FAIL write_hit_resp: got rdata=%h resps=%0d, want 11bb00dd 1", rd, resp_total - r0);
        end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd, ew; logic [255:0] el; int cyc, at, er, ewr, s; bit to;
        s = plog.size();
        model_access(1'b1, 32'h224, 32'hDEAD_BEEF, 4'b1111, er, ewr, el, ew);
        cpu_access(1'b1, 32'h224, 32'hDEAD_BEEF, 4'b1111, rd, cyc, at, to);
        n_vec++;
        if (to || at - s != 2 || plog[s].is_write || plog[s].addr !== 32'h220) begin
            n_miss++; $display("FAIL write_miss_fetch: got %0d txns timeout=%0d, want read then write at 00000220", at - s, to);
        end
        n_vec++;
        if (!plog[s + 1].is_write || plog[s + 1].addr !== 32'h220 ||
            plog[s + 1].data[63:32] !== 32'hDEAD_BEEF || plog[s + 1].data !== el) begin
            n_miss++; $display("FAIL write_miss_wb: got addr=%h word1=%h, want 00000220 deadbeef",
                               plog[s + 1].addr, plog[s + 1].data[63:32]);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd, ew, a; logic [255:0] el; int cyc, at, er, ewr, s; bit to;
        int lats [3] = '{0, 1, 7};
        stab_err = 0;
        for (int i = 0; i < 3; i++) begin
            lat_fixed = lats[i];
            a = 32'h0 + 32'(lats[i] * 32) + 32'h8;
            s = plog.size();
            model_access(1'b0, a, '0, '0, er, ewr, el, ew);
            cpu_access(1'b0, a, '0, '0, rd, cyc, at, to);
            n_vec++;
            if (to || rd !== ew || at - s != er) begin
                n_miss++; $display("FAIL latency%0d_read: got rdata=%h txns=%0d, want %h %0d", lats[i], rd, at - s, ew, er);
            end
            s = plog.size();
            model_access(1'b1, a, 32'h0BAD_F00D, 4'b1001, er, ewr, el, ew);
            cpu_access(1'b1, a, 32'h0BAD_F00D, 4'b1001, rd, cyc, at, to);
            n_vec++;
            if (to || rd !== ew || at - s != 1 || plog[s].data !== el) begin
                n_miss++; $display("FAIL latency%0d_write: got rdata=%h txns=%0d, want %h 1", lats[i], rd, at - s, ew);
            end
        end
        n_vec++;
        if (stab_err != 0 || both_err != 0) begin
            n_miss++; $display("FAIL pmem_stability: got %0d unstable, %0d both-high, want 0 0", stab_err, both_err);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] rd, ew; logic [255:0] el; int cyc, at, er, ewr, s, r0; bit to, seen;
        lat_fixed = 7;
        s = plog.size();
        @(negedge clk);
        mem_read = 1'b1; mem_address = 32'h300;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read === 1'b1) seen = 1'b1;
        end
        #2;
        rst = 1'b0;
        mem_read = 1'b0;
        #1;
        n_vec++;
        if (!seen || {mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata} !== '0) begin
            n_miss++; $display("FAIL reset_mid_fetch: got fetch_seen=%0d pr=%b pa=%h, want 1 0 0", seen, pmem_read, pmem_address);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        ref_valid = 1'b0;
        r0 = resp_total;
        repeat (3) @(negedge clk);
        n_vec++;
        if (resp_total != r0 || plog.size() != s) begin
            n_miss++; $display("FAIL reset_no_resp: got resps=%0d txns=%0d, want 0 0", resp_total - r0, plog.size() - s);
        end
        lat_fixed = 1;
        model_access(1'b0, 32'h108, '0, '0, er, ewr, el, ew);
        cpu_access(1'b0, 32'h108, '0, '0, rd, cyc, at, to);
        n_vec++;
        if (to || at - s != 1 || plog[s].is_write || rd !== ew) begin
            n_miss++; $display("FAIL reset_refetch: got txns=%0d rdata=%h, want 1 %h", at - s, rd, ew);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, ew; logic [255:0] el; int cyc, at, er, ewr, s, r0; bit to;
        lat_fixed = -1;
        r0 = resp_total;
        for (int i = 0; i < 3; i++) begin
            s = plog.size();
            model_access(1'b0, 32'h3E0 + 32'(i * 4), '0, '0, er, ewr, el, ew);
            cpu_access(1'b0, 32'h3E0 + 32'(i * 4), '0, '0, rd, cyc, at, to);
            n_vec++;
            if (to || rd !== ew || at - s != er || (er == 0 && cyc != 1)) begin
                n_miss++; $display("FAIL back_to_back%0d: got rdata=%h cycles=%0d txns=%0d, want %h txns %0d", i, rd, cyc, at - s, ew, er);
            end
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (resp_total - r0 != 3) begin
            n_miss++; $display("FAIL back_to_back_resps: got %0d, want 3", resp_total - r0);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, ew, a, d; logic [255:0] el; logic [3:0] b;
        int cyc, at, er, ewr, s; bit to, wr;
        lat_fixed = -1;
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(3, 0) * 32 + $urandom_range(7, 0) * 4);
            wr = 1'($urandom_range(1, 0));
            d = $urandom;
            b = 4'($urandom_range(15, 0));
            s = plog.size();
            model_access(wr, a, d, b, er, ewr, el, ew);
            cpu_access(wr, a, d, b, rd, cyc, at, to);
            n_vec++;
            if (to || rd !== ew || at - s != er + ewr || plog.size() != at) begin
                n_miss++; $display("FAIL random%0d_resp: got rdata=%h txns=%0d, want %h %0d", i, rd, at - s, ew, er + ewr);
            end else if ((er == 1 && (plog[s].is_write || plog[s].addr !== {a[31:5], 5'b0})) ||
                         (ewr == 1 && (!plog[s + er].is_write || plog[s + er].addr !== {a[31:5], 5'b0} ||
                                       plog[s + er].data !== el))) begin
                n_vec++;
                n_miss++; $display("FAIL random%0d_pmem: got addr=%h, want %h", i, plog[s].addr, {a[31:5], 5'b0});
            end
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (resp_total != n_req || stab_err != 0 || both_err != 0) begin
            n_miss++; $display("FAIL resp_count: got %0d resps unstable=%0d both=%0d, want %0d 0 0", resp_total, stab_err, both_err, n_req);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_write_hit();
        test_write_miss();
        test_latency();
        test_reset_mid_fetch();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cpu_line_responder.md
Name: cpu_line_responder

Overview:
- Memory-side responder for the CPU's word-wide request/response memory interface (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata in; mem_resp/mem_rdata out).
- Translates each 32-bit CPU access into cacheline transactions on the physical-memory port.
- Keeps a single-entry line buffer, so repeated accesses to the same line avoid a physical read.
- Sits between cpu and physical memory; it is the baseline the two-way cache will later replace.

Parameters:
s_offset, 5, log2 of line size in bytes (line = 256 bits)
addr_width, 32, byte-address width on both ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_byte_enable  in  4  byte lanes for writes
mem_address  in  32  CPU byte address (word-aligned)
mem_wdata  in  32  CPU write data
mem_resp  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid only while mem_resp=1
pmem_read  out  1  line read request, held until pmem_resp
pmem_write  out  1  line write request, held until pmem_resp
pmem_address  out  32  line-aligned address (low s_offset bits zero)
pmem_wdata  out  256  line write data
pmem_rdata  in  256  line read data, valid with pmem_resp
pmem_resp  in  1  one-cycle physical completion pulse

Behaviour:
- Reset (rst=0, async): state IDLE; buf_valid=0; buf_tag, buf_data, and the latched address/wdata/byte-enable are 0; all outputs 0.
- Line buffer fields: buf_tag = address[31:s_offset]; buf_data is 256 bits. Hit = buf_valid and buf_tag equals the latched tag.
- Word select: word index = address[s_offset-1:2]; bits [1:0] are ignored.
- IDLE:
  - Transitions when mem_read or mem_write is sampled high.
  - Latches address, wdata, byte enable and op (write wins if both are high; the protocol forbids that case).
  - Read hit -> RESP. Write hit -> MERGE. Any miss -> FETCH.
- FETCH:
  - pmem_read=1; pmem_address = {tag, s_offset zeros}.
  - On pmem_resp: buf_data <- pmem_rdata, buf_tag <- tag, buf_valid <- 1.
  - Next state: RESP for a read, MERGE for a write.
- MERGE: for each lane i with byte_enable[i]=1, the selected word's byte i <- wdata byte i; other bytes unchanged. -> WB.
- WB:
  - pmem_write=1; pmem_wdata = buf_data; pmem_address as in FETCH.
  - On pmem_resp -> RESP (write-through; the buffer stays valid).
- RESP:
  - mem_resp=1 for exactly one cycle; mem_rdata = selected word of buf_data (reads and writes alike). -> IDLE.
  - The CPU deasserts its request after the response, so a request sampled in IDLE the next cycle is a new request.
- Latency, with request first sampled in cycle N:
  - Read hit: mem_resp at N+1.
  - Read miss: pmem_read from N+1; mem_resp the cycle after pmem_resp.
  - Write hit: MERGE at N+1, pmem_write from N+2; mem_resp the cycle after pmem_resp.
  - Write miss: FETCH, then MERGE, then WB, then RESP.
- Physical-port rules:
  - pmem_read and pmem_write are never both high.
  - pmem_address and pmem_wdata stay stable while a request is held.
  - pmem_resp outside FETCH/WB is ignored.
- Reset mid-transaction: abandon immediately, drop pmem_* requests, invalidate the buffer; no mem_resp is produced.
- All outputs come from the state register and buffer registers; there is no combinational path from CPU inputs to pmem_* outputs.

Decomposition:
- Shared package (e.g. the existing types package):
  - state enum {IDLE, FETCH, MERGE, WB, RESP}.
  - Line-width constant derived from s_offset.
  - Function merge_word(line, idx, wdata, be) returning the updated line.
- One sub-module, line_buffer: holds valid, tag and data; has load-line and merge-word write ports and a word-select read port.
- The FSM lives in the top level.

Test Plan:
- Read miss then hit:
  - Memory line 0x100 holds word k = 0x1111_0000+k. Read 0x108 -> pmem_read at 0x100, then mem_rdata=0x1111_0002.
  - Read 0x10C next -> mem_resp one cycle after the request with 0x1111_0003 and no pmem_read.
- Write hit with byte enables: after the above, write 0xAABBCCDD to 0x108 with be=0101 -> pmem_write line word 2 = 0x11BB00DD, other words unchanged; mem_resp once.
- Write miss: with the buffer on 0x100, write 0xDEADBEEF to 0x224 with be=1111 -> pmem_read 0x220, then pmem_write 0x220 with word 1 = 0xDEADBEEF.
- Variable memory latency: pmem_resp delayed 0, 1 and 7 cycles -> requests and addresses held stable; exactly one mem_resp per CPU request; mem_resp never before the matching pmem_resp.
- Reset mid-FETCH: drop rst for one cycle while pmem_read=1 -> all outputs 0, buffer invalid; the next read to the same line issues pmem_read again.
- Back-to-back requests: a new read presented the cycle after mem_resp is accepted; no duplicate response to the previous request.
